// File: rtl/protocolo_rtc_pkg.sv
// Shared definitions for the RTC bus master: state encoding, phase lengths
// and strobe polarities.
package protocolo_rtc_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ADDR_SETUP  = 3'd1,
        ADDR_STROBE = 3'd2,
        ADDR_HOLD   = 3'd3,
        DATA_SETUP  = 3'd4,
        DATA_STROBE = 3'd5,
        DATA_HOLD   = 3'd6,
        RECOVER     = 3'd7
    } state_t;

    // Phase lengths in clock cycles
    localparam int unsigned LEN_SETUP   = 2;
    localparam int unsigned LEN_STROBE  = 10;
    localparam int unsigned LEN_HOLD    = 2;
    localparam int unsigned LEN_RECOVER = 4;

    // Pin polarities
    localparam logic CS_ON      = 1'b0;
    localparam logic CS_OFF     = 1'b1;
    localparam logic STB_ON     = 1'b0;
    localparam logic STB_OFF    = 1'b1;
    localparam logic AOD_ADDR   = 1'b0;
    localparam logic AOD_DATA   = 1'b1;
    localparam logic TYPE_WRITE = 1'b1;

    // Value loaded into the phase timer on entry to a state; the timer
    // reports done when it reaches zero, i.e. on the last cycle of the phase.
    function automatic logic [3:0] phase_load(input state_t s);
        logic [3:0] v;
        case (s)
            ADDR_SETUP, DATA_SETUP:   v = 4'(LEN_SETUP - 1);
            ADDR_STROBE, DATA_STROBE: v = 4'(LEN_STROBE - 1);
            ADDR_HOLD, DATA_HOLD:     v = 4'(LEN_HOLD - 1);
            RECOVER:                  v = 4'(LEN_RECOVER - 1);
            default:                  v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/protocolo_rtc_timer.sv
// Loadable 4-bit down-counter that flags the last cycle of a bus phase.
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       done_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Load on phase entry, otherwise count down and stick at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= 4'd0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/protocolo_rtc.sv
// Bus master for a parallel RTC with multiplexed address/data bus.
// Each level change on IndicadorMaquina launches one 32-cycle transaction
// (write when 1, read when 0); read data is forwarded to the display.
module protocolo_rtc
    import protocolo_rtc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       IndicadorMaquina,
    input  logic [7:0] address,
    input  logic [7:0] DATA_WRITE,
    input  logic       camb_hora,
    input  logic       camb_fecha,
    input  logic       camb_crono,
    output logic       ChipSelect,
    output logic       Write,
    output logic       Read,
    output logic       AoD,
    inout  wire  [7:0] DATA_ADDRESS,
    output logic [7:0] data_vga
);

    logic       ind_sync_q, ind_prev_q, force_q, trig_q;
    state_t     state_q, state_d;
    logic       start;
    logic       pending_q, pending_d;
    logic       type_q, type_d;
    logic [7:0] addr_q, addr_d, data_q, data_d;
    logic       cs_q, wr_q, rd_q, aod_q, drv_en_q;
    logic       cs_d, wr_d, rd_d, aod_d, drv_en_d;
    logic [7:0] bus_out_q, bus_out_d;
    logic [7:0] rd_data_q, vga_q;
    logic       tmr_load, tmr_done;
    logic [3:0] tmr_val;

    // Input sync plus edge detect; reset preloads both flops so it creates no
    // edge, and instead arms a single forced trigger for the first cycle out.
    always_ff @(posedge clk) begin
        if (reset) begin
            ind_sync_q <= IndicadorMaquina;
            ind_prev_q <= IndicadorMaquina;
            force_q    <= 1'b1;
            trig_q     <= 1'b0;
        end else begin
            ind_sync_q <= IndicadorMaquina;
            ind_prev_q <= ind_sync_q;
            force_q    <= 1'b0;
            trig_q     <= force_q | (ind_sync_q ^ ind_prev_q);
        end
    end

    // Phase sequencing; a trigger that lands on the last RECOVER cycle chains
    // straight into the next transaction just like a pending one.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE:        start = trig_q;
            ADDR_SETUP:  if (tmr_done) state_d = ADDR_STROBE;
            ADDR_STROBE: if (tmr_done) state_d = ADDR_HOLD;
            ADDR_HOLD:   if (tmr_done) state_d = DATA_SETUP;
            DATA_SETUP:  if (tmr_done) state_d = DATA_STROBE;
            DATA_STROBE: if (tmr_done) state_d = DATA_HOLD;
            DATA_HOLD:   if (tmr_done) state_d = RECOVER;
            RECOVER: begin
                if (tmr_done) begin
                    if (pending_q || trig_q) start = 1'b1;
                    else                     state_d = IDLE;
                end
            end
            default:     state_d = IDLE;
        endcase
        if (start) state_d = ADDR_SETUP;
        tmr_load  = (state_d != state_q);
        tmr_val   = phase_load(state_d);
        pending_d = start ? 1'b0 : (pending_q | trig_q);
        type_d    = start ? ind_sync_q : type_q;
        addr_d    = start ? address    : addr_q;
        data_d    = start ? DATA_WRITE : data_q;
    end

    // Pin values decoded from the next state so they register with it
    always_comb begin
        cs_d      = CS_OFF;
        wr_d      = STB_OFF;
        rd_d      = STB_OFF;
        aod_d     = AOD_DATA;
        drv_en_d  = 1'b0;
        bus_out_d = addr_d;
        unique case (state_d)
            ADDR_SETUP, ADDR_HOLD: begin
                cs_d = CS_ON; aod_d = AOD_ADDR; drv_en_d = 1'b1;
            end
            ADDR_STROBE: begin
                cs_d = CS_ON; aod_d = AOD_ADDR; drv_en_d = 1'b1; wr_d = STB_ON;
            end
            DATA_SETUP, DATA_HOLD: begin
                cs_d = CS_ON; drv_en_d = (type_d == TYPE_WRITE); bus_out_d = data_d;
            end
            DATA_STROBE: begin
                cs_d = CS_ON; drv_en_d = (type_d == TYPE_WRITE); bus_out_d = data_d;
                if (type_d == TYPE_WRITE) wr_d = STB_ON;
                else                      rd_d = STB_ON;
            end
            default: ;
        endcase
    end

    // Control state and registered pins
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            cs_q      <= CS_OFF;
            wr_q      <= STB_OFF;
            rd_q      <= STB_OFF;
            aod_q     <= AOD_DATA;
            drv_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cs_q      <= cs_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            aod_q     <= aod_d;
            drv_en_q  <= drv_en_d;
        end
    end

    // Latched transaction operands and bus output value
    always_ff @(posedge clk) begin
        type_q    <= type_d;
        addr_q    <= addr_d;
        data_q    <= data_d;
        bus_out_q <= bus_out_d;
    end

    // Read capture on the final strobe cycle, then the display mux
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= 8'h00;
            vga_q     <= 8'h00;
        end else begin
            if (state_q == DATA_STROBE && tmr_done && type_q != TYPE_WRITE)
                rd_data_q <= DATA_ADDRESS;
            vga_q <= (camb_hora | camb_fecha | camb_crono) ? DATA_WRITE : rd_data_q;
        end
    end

    rtc_phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    assign DATA_ADDRESS = drv_en_q ? bus_out_q : 8'hZZ;
    assign ChipSelect   = cs_q;
    assign Write        = wr_q;
    assign Read         = rd_q;
    assign AoD          = aod_q;
    assign data_vga     = vga_q;

endmodule

// File: tb/tb_protocolo_rtc.sv
// Bench for protocolo_rtc: transaction-level reference model, per-cycle
// compare, directed literal checks and randomized toggling.
module tb_protocolo_rtc;

    logic       clk = 1'b0;
    logic       reset;
    logic       IndicadorMaquina;
    logic [7:0] address, DATA_WRITE;
    logic       camb_hora, camb_fecha, camb_crono;
    logic       ChipSelect, Write, Read, AoD;
    logic [7:0] data_vga;
    logic [7:0] tb_val;
    wire  [7:0] bus;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // RTC side: drives the bus only while the read strobe is low; an
    // undriven bus floats high.
    assign bus = (Read == 1'b0) ? tb_val : 8'hZZ;
    pullup pu_bus (bus);

    always #5 clk = ~clk;

    protocolo_rtc dut (
        .clk              (clk),
        .reset            (reset),
        .IndicadorMaquina (IndicadorMaquina),
        .address          (address),
        .DATA_WRITE       (DATA_WRITE),
        .camb_hora        (camb_hora),
        .camb_fecha       (camb_fecha),
        .camb_crono       (camb_crono),
        .ChipSelect       (ChipSelect),
        .Write            (Write),
        .Read             (Read),
        .AoD              (AoD),
        .DATA_ADDRESS     (bus),
        .data_vga         (data_vga)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    // Reference model: m_off is the offset (0..31) of the cycle on display
    // within the current transaction, -1 when idle. Triggers take effect two
    // edges after the toggle is sampled, or one edge after reset release.
    int         m_edge = 0;
    int         m_off  = -1;
    bit         m_pend = 1'b0;
    bit         m_type = 1'b0;
    bit         m_last_in = 1'b0;
    bit         m_was_rst = 1'b0;
    logic [7:0] m_addr = 8'h00, m_data = 8'h00, m_rd = 8'h00, m_vga = 8'h00;
    int         m_trig[$];

    always @(posedge clk) begin : model
        bit         fire;
        logic [7:0] vga_next;
        fire = 1'b0;
        if (reset) begin
            m_off = -1; m_pend = 1'b0; m_rd = 8'h00; m_vga = 8'h00;
            m_trig.delete();
            m_last_in = IndicadorMaquina;
            m_was_rst = 1'b1;
        end else begin
            while (m_trig.size() > 0 && m_trig[0] <= m_edge) begin
                fire = 1'b1;
                void'(m_trig.pop_front());
            end
            if (m_was_rst) m_trig.push_back(m_edge + 1);
            if (IndicadorMaquina != m_last_in) m_trig.push_back(m_edge + 2);
            vga_next = (camb_hora | camb_fecha | camb_crono) ? DATA_WRITE : m_rd;
            if (m_off == 25 && !m_type) m_rd = tb_val;
            m_vga = vga_next;
            if (m_off >= 0) m_off++;
            if ((m_off < 0 && fire) || (m_off == 32 && (fire || m_pend))) begin
                m_off = 0; m_addr = address; m_data = DATA_WRITE;
                m_type = m_last_in; m_pend = 1'b0;
            end else if (m_off == 32) begin
                m_off = -1;
            end else if (m_off >= 0 && fire) begin
                m_pend = 1'b1;
            end
            m_last_in = IndicadorMaquina;
            m_was_rst = 1'b0;
        end
        m_edge++;
    end

    // Per-cycle compare, 2 time units after the active edge
    always @(posedge clk) begin : cmp
        logic       e_cs, e_wr, e_rd, e_aod;
        logic [7:0] e_bus;
        #2;
        if (chk_en) begin
            e_cs = 1'b1; e_wr = 1'b1; e_rd = 1'b1; e_aod = 1'b1; e_bus = 8'hFF;
            if (m_off >= 0 && m_off < 28) begin
                e_cs = 1'b0;
                if (m_off < 14) begin
                    e_aod = 1'b0;
                    e_bus = m_addr;
                    if (m_off >= 2 && m_off < 12) e_wr = 1'b0;
                end else begin
                    e_bus = m_type ? m_data : 8'hFF;
                    if (m_off >= 16 && m_off < 26) begin
                        if (m_type) e_wr = 1'b0;
                        else begin e_rd = 1'b0; e_bus = tb_val; end
                    end
                end
            end
            chk("cs",  ChipSelect, e_cs);
            chk("wr",  Write,      e_wr);
            chk("rd",  Read,       e_rd);
            chk("aod", AoD,        e_aod);
            chk("bus", bus,        e_bus);
            chk("vga", data_vga,   m_vga);
            chk("wr_rd_excl", Write | Read, 1'b1);
        end
    end

    task automatic rnd_inputs();
        address    = 8'($urandom);
        DATA_WRITE = 8'($urandom);
        tb_val     = 8'($urandom);
        camb_hora  = ($urandom_range(0, 15) == 0);
        camb_fecha = ($urandom_range(0, 15) == 0);
        camb_crono = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        int cs_low, wr_addr, wr_data, rd_low, rlast, vfirst, falls, wlow;
        logic prev_cs;
        bit found;

        reset = 1'b1; IndicadorMaquina = 1'b1; address = 8'h0A; DATA_WRITE = 8'h0F;
        camb_hora = 1'b0; camb_fecha = 1'b0; camb_crono = 1'b0; tb_val = 8'h00;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cs",  ChipSelect, 1'b1);
        chk("rst_wr",  Write,      1'b1);
        chk("rst_rd",  Read,       1'b1);
        chk("rst_aod", AoD,        1'b1);
        chk("rst_bus", bus,        8'hFF);
        chk("rst_vga", data_vga,   8'h00);

        // Forced post-reset write of 0x0F to 0x0A
        reset = 1'b0;
        cs_low = 0; wr_addr = 0; wr_data = 0; rd_low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!ChipSelect) cs_low++;
            if (!Write && !AoD && bus == 8'h0A) wr_addr++;
            if (!Write && AoD && bus == 8'h0F) wr_data++;
            if (!Read) rd_low++;
        end
        chk("w1_cs_low",  8'(cs_low),  8'd28);
        chk("w1_wr_addr", 8'(wr_addr), 8'd10);
        chk("w1_wr_data", 8'(wr_data), 8'd10);
        chk("w1_rd_low",  8'(rd_low),  8'd0);

        // Read returning 0x5A
        IndicadorMaquina = 1'b0; tb_val = 8'h5A;
        rd_low = 0; rlast = -1; vfirst = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!Read) begin rd_low++; rlast = i; end
            if (vfirst < 0 && data_vga == 8'h5A) vfirst = i;
        end
        chk("r1_rd_low", 8'(rd_low), 8'd10);
        chk("r1_vga", data_vga, 8'h5A);
        chk("r1_vga_delay", 8'(vfirst - rlast), 8'd2);

        // Edit-mode override of the display value
        camb_hora = 1'b1;
        @(negedge clk);
        chk("camb_on", data_vga, 8'h0F);
        camb_hora = 1'b0;
        @(negedge clk);
        chk("camb_off", data_vga, 8'h5A);

        // Two extra toggles during one write -> one follow-on write
        falls = 0; wlow = 0; rd_low = 0; prev_cs = ChipSelect;
        for (int i = 0; i < 116; i++) begin
            if (i == 0)  IndicadorMaquina = 1'b1;
            if (i == 10) IndicadorMaquina = 1'b0;
            if (i == 16) IndicadorMaquina = 1'b1;
            @(negedge clk);
            if (prev_cs && !ChipSelect) falls++;
            prev_cs = ChipSelect;
            if (!Write) wlow++;
            if (!Read) rd_low++;
        end
        chk("dbl_transactions", 8'(falls),  8'd2);
        chk("dbl_wr_low",       8'(wlow),   8'd40);
        chk("dbl_rd_low",       8'(rd_low), 8'd0);

        // Reset in the middle of a write data strobe
        IndicadorMaquina = 1'b0; tb_val = 8'h3C;
        repeat (40) @(negedge clk);
        IndicadorMaquina = 1'b1; DATA_WRITE = 8'hA5;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (!ChipSelect && AoD && !Write) found = 1'b1;
        end
        chk("wait_dstrobe", 8'(found), 8'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs",  ChipSelect, 1'b1);
        chk("mid_rst_wr",  Write,      1'b1);
        chk("mid_rst_rd",  Read,       1'b1);
        chk("mid_rst_aod", AoD,        1'b1);
        chk("mid_rst_bus", bus,        8'hFF);
        chk("mid_rst_vga", data_vga,   8'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        // Regular toggling, 256 cycles apart
        for (int p = 0; p < 8; p++) begin
            IndicadorMaquina = ~IndicadorMaquina;
            for (int i = 0; i < 256; i++) begin
                rnd_inputs();
                @(negedge clk);
            end
        end

        // Irregular toggling with overlaps and occasional resets
        for (int p = 0; p < 16; p++) begin
            IndicadorMaquina = ~IndicadorMaquina;
            for (int i = 0; i < int'($urandom_range(3, 70)); i++) begin
                rnd_inputs();
                @(negedge clk);
            end
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        for (int i = 0; i < 100; i++) begin
            rnd_inputs();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
